// File: rtl/matrix_multiply_gen.sv
// -----------------------------------------------------------------------------
// matrix_multiply_gen
//
// Computes RES = A x B for an A_rows x A_cols matrix A and an A_cols x B_cols
// matrix B. All three matrices live row-major in synchronous-read RAMs with
// one cycle of read latency. One (A,B) element pair is issued per clock in
// i-outer / j-middle / k-inner order. Products are widened into an
// accumulator, and on the last k of each dot product the sum is logically
// right-shifted by out_shift, then either clamped to 2^width-1 (saturate=1)
// or truncated to width bits (saturate=0), and written to RES.
//
// Ports
//   clk, reset          single rising-edge clock, synchronous active-high reset
//   Start               run request (level), sampled only in IDLE
//   Done                run complete, held until Start is sampled low
//   Busy                high while elements are issued or results drain
//   A_read_en/_address  A RAM read port, address i*A_cols+k
//   A_read_data_out     A RAM data, valid one cycle after the address
//   B_read_en/_address  B RAM read port, address k*B_cols+j
//   B_read_data_out     B RAM data, valid one cycle after the address
//   RES_write_en        one-cycle pulse per result
//   RES_write_address   i*B_cols+j, advances once per write
//   RES_write_data_in   shifted and clipped result
//
// Pipeline
//   E(t)   : element t address/enable registered (issue stage)
//   E(t+1) : element t data appears, its k flags move to stage 1
//   E(t+2) : element t accumulated; a result is registered when k==A_cols-1
// -----------------------------------------------------------------------------
module matrix_multiply_gen #(
  parameter int width     = 8,
  parameter int A_rows    = 2,
  parameter int A_cols    = 4,
  parameter int B_cols    = 2,
  parameter int acc_width = 2*width + $clog2(A_cols) + 1,
  parameter int out_shift = 0,
  parameter int saturate  = 1,
  localparam int A_bits = (A_rows*A_cols > 1) ? $clog2(A_rows*A_cols) : 1,
  localparam int B_bits = (A_cols*B_cols > 1) ? $clog2(A_cols*B_cols) : 1,
  localparam int R_bits = (A_rows*B_cols > 1) ? $clog2(A_rows*B_cols) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  output logic              Done,
  output logic              Busy,
  output logic              A_read_en,
  output logic [A_bits-1:0] A_read_address,
  input  logic [width-1:0]  A_read_data_out,
  output logic              B_read_en,
  output logic [B_bits-1:0] B_read_address,
  input  logic [width-1:0]  B_read_data_out,
  output logic              RES_write_en,
  output logic [R_bits-1:0] RES_write_address,
  output logic [width-1:0]  RES_write_data_in
);

  // Counter widths; a dimension of 1 still gets a 1-bit counter.
  localparam int I_W = (A_rows > 1) ? $clog2(A_rows) : 1;
  localparam int J_W = (B_cols > 1) ? $clog2(B_cols) : 1;
  localparam int K_W = (A_cols > 1) ? $clog2(A_cols) : 1;

  localparam logic [I_W-1:0]       I_LAST  = I_W'(A_rows - 1);
  localparam logic [J_W-1:0]       J_LAST  = J_W'(B_cols - 1);
  localparam logic [K_W-1:0]       K_LAST  = K_W'(A_cols - 1);
  localparam logic [I_W-1:0]       I_ONE   = I_W'(1);
  localparam logic [J_W-1:0]       J_ONE   = J_W'(1);
  localparam logic [K_W-1:0]       K_ONE   = K_W'(1);
  localparam logic [R_bits-1:0]    R_LAST  = R_bits'(A_rows*B_cols - 1);
  localparam logic [R_bits-1:0]    R_ONE   = R_bits'(1);
  localparam logic [acc_width-1:0] SAT_MAX = acc_width'({width{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Clamp or truncate a shifted sum to the RES element width.
  function automatic logic [width-1:0] clip_fn(input logic [acc_width-1:0] v);
    logic [width-1:0] r;
    if ((saturate != 0) && (v > SAT_MAX)) begin
      r = {width{1'b1}};
    end else begin
      r = v[width-1:0];
    end
    return r;
  endfunction

  // FSM and registered status
  state_t state_r;
  state_t state_s;
  logic   done_r;
  logic   busy_r;
  logic   done_s;
  logic   busy_s;

  // Issue stage: indices of the element whose address is on the RAM ports
  logic [I_W-1:0]    i_r;
  logic [J_W-1:0]    j_r;
  logic [K_W-1:0]    k_r;
  logic [I_W-1:0]    i_s;
  logic [J_W-1:0]    j_s;
  logic [K_W-1:0]    k_s;
  logic              rd_en_r;
  logic              rd_en_s;
  logic [A_bits-1:0] a_addr_r;
  logic [A_bits-1:0] a_addr_s;
  logic [B_bits-1:0] b_addr_r;
  logic [B_bits-1:0] b_addr_s;
  logic              last_issued_s;

  // Stage 1: flags travelling alongside the read data
  logic v1_r;
  logic first1_r;
  logic last1_r;

  // Accumulate / write stage
  logic [2*width-1:0]   prod_s;
  logic [acc_width-1:0] sum_s;
  logic [acc_width-1:0] shifted_s;
  logic [acc_width-1:0] acc_r;
  logic [R_bits-1:0]    wcnt_r;
  logic                 we_r;
  logic [R_bits-1:0]    waddr_r;
  logic [width-1:0]     wdata_r;

  assign Done              = done_r;
  assign Busy              = busy_r;
  assign A_read_en         = rd_en_r;
  assign B_read_en         = rd_en_r;
  assign A_read_address    = a_addr_r;
  assign B_read_address    = b_addr_r;
  assign RES_write_en      = we_r;
  assign RES_write_address = waddr_r;
  assign RES_write_data_in = wdata_r;

  // The element on the ports is the final one of the run.
  assign last_issued_s = rd_en_r && (i_r == I_LAST) && (j_r == J_LAST) && (k_r == K_LAST);

  // Zero-extend operands first so the full 2*width product is kept.
  assign prod_s    = {{width{1'b0}}, A_read_data_out} * {{width{1'b0}}, B_read_data_out};
  assign sum_s     = (first1_r ? {acc_width{1'b0}} : acc_r) + acc_width'(prod_s);
  assign shifted_s = sum_s >> out_shift;

  // State register plus registered Done/Busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (Start) begin
          state_s = S_RUN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_issued_s) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DRAIN: begin
        // The final result always lands at the last RES address.
        if (we_r && (waddr_r == R_LAST)) begin
          state_s = S_DONE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_DONE: begin
        if (!Start) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Status outputs derived from the next state so they register in step with it.
  always_comb begin
    done_s = 1'b0;
    busy_s = 1'b0;
    case (state_s)
      S_IDLE:  begin done_s = 1'b0; busy_s = 1'b0; end
      S_RUN:   begin done_s = 1'b0; busy_s = 1'b1; end
      S_DRAIN: begin done_s = 1'b0; busy_s = 1'b1; end
      S_DONE:  begin done_s = 1'b1; busy_s = 1'b0; end
      default: begin done_s = 1'b0; busy_s = 1'b0; end
    endcase
  end

  // Next element indices and RAM addresses for the issue stage.
  always_comb begin
    rd_en_s  = 1'b0;
    i_s      = i_r;
    j_s      = j_r;
    k_s      = k_r;
    a_addr_s = a_addr_r;
    b_addr_s = b_addr_r;
    if ((state_r == S_IDLE) && Start) begin
      rd_en_s  = 1'b1;
      i_s      = {I_W{1'b0}};
      j_s      = {J_W{1'b0}};
      k_s      = {K_W{1'b0}};
      a_addr_s = {A_bits{1'b0}};
      b_addr_s = {B_bits{1'b0}};
    end else if ((state_r == S_RUN) && !last_issued_s) begin
      rd_en_s = 1'b1;
      if (k_r == K_LAST) begin
        k_s = {K_W{1'b0}};
        if (j_r == J_LAST) begin
          j_s = {J_W{1'b0}};
          i_s = i_r + I_ONE;
        end else begin
          j_s = j_r + J_ONE;
          i_s = i_r;
        end
      end else begin
        k_s = k_r + K_ONE;
        j_s = j_r;
        i_s = i_r;
      end
      a_addr_s = A_bits'(int'(i_s) * A_cols + int'(k_s));
      b_addr_s = B_bits'(int'(k_s) * B_cols + int'(j_s));
    end else begin
      // Addresses hold their last value; only the enables drop.
      rd_en_s = 1'b0;
    end
  end

  // Issue stage, read-data flag pipeline, accumulator and RES write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_r  <= 1'b0;
      i_r      <= {I_W{1'b0}};
      j_r      <= {J_W{1'b0}};
      k_r      <= {K_W{1'b0}};
      a_addr_r <= {A_bits{1'b0}};
      b_addr_r <= {B_bits{1'b0}};
      v1_r     <= 1'b0;
      first1_r <= 1'b0;
      last1_r  <= 1'b0;
      acc_r    <= {acc_width{1'b0}};
      wcnt_r   <= {R_bits{1'b0}};
      we_r     <= 1'b0;
      waddr_r  <= {R_bits{1'b0}};
      wdata_r  <= {width{1'b0}};
    end else begin
      rd_en_r  <= rd_en_s;
      i_r      <= i_s;
      j_r      <= j_s;
      k_r      <= k_s;
      a_addr_r <= a_addr_s;
      b_addr_r <= b_addr_s;

      v1_r     <= rd_en_r;
      first1_r <= (k_r == {K_W{1'b0}});
      last1_r  <= (k_r == K_LAST);

      if (v1_r) begin
        acc_r <= sum_s;
      end else begin
        acc_r <= acc_r;
      end

      if (v1_r && last1_r) begin
        we_r    <= 1'b1;
        waddr_r <= wcnt_r;
        wdata_r <= clip_fn(shifted_s);
        // Wraps to 0 only after the last result of the run.
        if (wcnt_r == R_LAST) begin
          wcnt_r <= {R_bits{1'b0}};
        end else begin
          wcnt_r <= wcnt_r + R_ONE;
        end
      end else begin
        we_r <= 1'b0;
        if (state_r == S_IDLE) begin
          wcnt_r <= {R_bits{1'b0}};
        end else begin
          wcnt_r <= wcnt_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_multiply_gen.sv
// Bench for matrix_multiply_gen. Five instances share clock, reset and Start:
//   0 main  : 2x4 * 4x2, shift 0,  saturate
//   1 shift : 2x4 * 4x2, shift 10, saturate
//   2 nosat : 2x4 * 4x2, shift 0,  truncate
//   3 m1    : 2x1 * 1x3 (write every cycle)
//   4 dot   : 1x4 * 4x1 (dot product)
// Expected writes are queued per instance when a run is started and popped
// as the instance pulses RES_write_en.
module tb_matrix_multiply_gen;

  logic clk = 1'b0;
  logic reset;
  logic start;

  always #5 clk = ~clk;

  localparam int CFG_N[5]   = '{2, 2, 2, 2, 1};
  localparam int CFG_M[5]   = '{4, 4, 4, 1, 4};
  localparam int CFG_P[5]   = '{2, 2, 2, 3, 1};
  localparam int CFG_SH[5]  = '{0, 10, 0, 0, 0};
  localparam int CFG_SAT[5] = '{1, 1, 0, 1, 1};

  // RAM contents: instances 0..2 share mem_a/mem_b
  logic [7:0] mem_a [8];
  logic [7:0] mem_b [8];
  logic [7:0] mem_ua[2];
  logic [7:0] mem_ub[4];
  logic [7:0] mem_da[4];
  logic [7:0] mem_db[4];

  // Instance 0
  logic m_done, m_busy, m_aen, m_ben, m_we;
  logic [2:0] m_aaddr, m_baddr;
  logic [1:0] m_waddr;
  logic [7:0] m_wdata, m_adata, m_bdata;
  // Instance 1
  logic s_done, s_busy, s_aen, s_ben, s_we;
  logic [2:0] s_aaddr, s_baddr;
  logic [1:0] s_waddr;
  logic [7:0] s_wdata, s_adata, s_bdata;
  // Instance 2
  logic n_done, n_busy, n_aen, n_ben, n_we;
  logic [2:0] n_aaddr, n_baddr;
  logic [1:0] n_waddr;
  logic [7:0] n_wdata, n_adata, n_bdata;
  // Instance 3
  logic u_done, u_busy, u_aen, u_ben, u_we;
  logic [0:0] u_aaddr;
  logic [1:0] u_baddr;
  logic [2:0] u_waddr;
  logic [7:0] u_wdata, u_adata, u_bdata;
  // Instance 4
  logic d_done, d_busy, d_aen, d_ben, d_we;
  logic [1:0] d_aaddr, d_baddr;
  logic [0:0] d_waddr;
  logic [7:0] d_wdata, d_adata, d_bdata;

  matrix_multiply_gen u_main (
    .clk(clk), .reset(reset), .Start(start), .Done(m_done), .Busy(m_busy),
    .A_read_en(m_aen), .A_read_address(m_aaddr), .A_read_data_out(m_adata),
    .B_read_en(m_ben), .B_read_address(m_baddr), .B_read_data_out(m_bdata),
    .RES_write_en(m_we), .RES_write_address(m_waddr), .RES_write_data_in(m_wdata));

  matrix_multiply_gen #(.out_shift(10)) u_shift (
    .clk(clk), .reset(reset), .Start(start), .Done(s_done), .Busy(s_busy),
    .A_read_en(s_aen), .A_read_address(s_aaddr), .A_read_data_out(s_adata),
    .B_read_en(s_ben), .B_read_address(s_baddr), .B_read_data_out(s_bdata),
    .RES_write_en(s_we), .RES_write_address(s_waddr), .RES_write_data_in(s_wdata));

  matrix_multiply_gen #(.saturate(0)) u_nosat (
    .clk(clk), .reset(reset), .Start(start), .Done(n_done), .Busy(n_busy),
    .A_read_en(n_aen), .A_read_address(n_aaddr), .A_read_data_out(n_adata),
    .B_read_en(n_ben), .B_read_address(n_baddr), .B_read_data_out(n_bdata),
    .RES_write_en(n_we), .RES_write_address(n_waddr), .RES_write_data_in(n_wdata));

  matrix_multiply_gen #(.A_rows(2), .A_cols(1), .B_cols(3)) u_m1 (
    .clk(clk), .reset(reset), .Start(start), .Done(u_done), .Busy(u_busy),
    .A_read_en(u_aen), .A_read_address(u_aaddr), .A_read_data_out(u_adata),
    .B_read_en(u_ben), .B_read_address(u_baddr), .B_read_data_out(u_bdata),
    .RES_write_en(u_we), .RES_write_address(u_waddr), .RES_write_data_in(u_wdata));

  matrix_multiply_gen #(.A_rows(1), .A_cols(4), .B_cols(1)) u_dot (
    .clk(clk), .reset(reset), .Start(start), .Done(d_done), .Busy(d_busy),
    .A_read_en(d_aen), .A_read_address(d_aaddr), .A_read_data_out(d_adata),
    .B_read_en(d_ben), .B_read_address(d_baddr), .B_read_data_out(d_bdata),
    .RES_write_en(d_we), .RES_write_address(d_waddr), .RES_write_data_in(d_wdata));

  // Synchronous-read RAM models, one cycle latency
  always @(posedge clk) begin
    if (m_aen) m_adata <= mem_a[m_aaddr];
    if (m_ben) m_bdata <= mem_b[m_baddr];
    if (s_aen) s_adata <= mem_a[s_aaddr];
    if (s_ben) s_bdata <= mem_b[s_baddr];
    if (n_aen) n_adata <= mem_a[n_aaddr];
    if (n_ben) n_bdata <= mem_b[n_baddr];
    if (u_aen) u_adata <= mem_ua[u_aaddr];
    if (u_ben) u_bdata <= mem_ub[u_baddr];
    if (d_aen) d_adata <= mem_da[d_aaddr];
    if (d_ben) d_bdata <= mem_db[d_baddr];
  end

  // Write ports gathered for the scoreboard
  logic [4:0] mon_we;
  logic [7:0] mon_addr[5];
  logic [7:0] mon_data[5];
  assign mon_we      = {d_we, u_we, n_we, s_we, m_we};
  assign mon_addr[0] = {6'd0, m_waddr};
  assign mon_addr[1] = {6'd0, s_waddr};
  assign mon_addr[2] = {6'd0, n_waddr};
  assign mon_addr[3] = {5'd0, u_waddr};
  assign mon_addr[4] = {7'd0, d_waddr};
  assign mon_data[0] = m_wdata;
  assign mon_data[1] = s_wdata;
  assign mon_data[2] = n_wdata;
  assign mon_data[3] = u_wdata;
  assign mon_data[4] = d_wdata;

  logic [15:0] exp_q[5][$];
  int n_vec  = 0;
  int n_miss = 0;

  function automatic int elem_a(int d, int idx);
    if (d == 3) return int'(mem_ua[idx]);
    else if (d == 4) return int'(mem_da[idx]);
    else return int'(mem_a[idx]);
  endfunction

  function automatic int elem_b(int d, int idx);
    if (d == 3) return int'(mem_ub[idx]);
    else if (d == 4) return int'(mem_db[idx]);
    else return int'(mem_b[idx]);
  endfunction

  // Golden dot product, shift and clip for result (i,j) of instance d
  function automatic int golden(int d, int i, int j);
    int s;
    s = 0;
    for (int k = 0; k < CFG_M[d]; k++)
      s += elem_a(d, i*CFG_M[d] + k) * elem_b(d, k*CFG_P[d] + j);
    s = s >> CFG_SH[d];
    if (CFG_SAT[d] != 0) begin
      if (s > 255) s = 255;
    end else begin
      s = s % 256;
    end
    return s;
  endfunction

  task automatic push_all();
    for (int d = 0; d < 5; d++)
      for (int i = 0; i < CFG_N[d]; i++)
        for (int j = 0; j < CFG_P[d]; j++)
          exp_q[d].push_back({8'(i*CFG_P[d] + j), 8'(golden(d, i, j))});
  endtask

  // mode 0: all ones, 1: all 255, 3: pattern on shared RAMs, else random
  task automatic fill_mem(input int mode);
    for (int x = 0; x < 8; x++) begin
      case (mode)
        0: begin mem_a[x] = 8'd1;   mem_b[x] = 8'd1;   end
        1: begin mem_a[x] = 8'd255; mem_b[x] = 8'd255; end
        3: begin
          mem_a[x] = 8'(x + 1);
          mem_b[x] = (x == 0 || x == 3 || x == 4 || x == 7) ? 8'd1 : 8'd0;
        end
        default: begin mem_a[x] = 8'($urandom_range(0, 255)); mem_b[x] = 8'($urandom_range(0, 255)); end
      endcase
    end
    for (int x = 0; x < 4; x++) begin
      if (mode == 0) begin
        mem_ua[x % 2] = 8'd1; mem_ub[x] = 8'd1; mem_da[x] = 8'd1; mem_db[x] = 8'd1;
      end else if (mode == 1) begin
        mem_ua[x % 2] = 8'd255; mem_ub[x] = 8'd255; mem_da[x] = 8'd255; mem_db[x] = 8'd255;
      end else begin
        mem_ua[x % 2] = 8'($urandom_range(0, 255)); mem_ub[x] = 8'($urandom_range(0, 255));
        mem_da[x] = 8'($urandom_range(0, 255));     mem_db[x] = 8'($urandom_range(0, 255));
      end
    end
  endtask

  // Advance one clock; sample after the falling edge and pop the scoreboard
  task automatic step_cycle();
    logic [15:0] want;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 5; d++) begin
      if (mon_we[d] === 1'b1) begin
        n_vec++;
        if (exp_q[d].size() == 0) begin
          n_miss++;
          $display("FAIL sb_extra_write dut%0d: got addr=%0d data=%0d, required no write",
                   d, mon_addr[d], mon_data[d]);
        end else begin
          want = exp_q[d].pop_front();
          if ({mon_addr[d], mon_data[d]} !== want) begin
            n_miss++;
            $display("FAIL sb_write dut%0d: got addr=%0d data=%0d, required addr=%0d data=%0d",
                     d, mon_addr[d], mon_data[d], want[15:8], want[7:0]);
          end
        end
      end
    end
  endtask

  task automatic check_drained(input string tag);
    for (int d = 0; d < 5; d++) begin
      n_vec++;
      if (exp_q[d].size() != 0) begin
        n_miss++;
        $display("FAIL %s_missing_writes dut%0d: got %0d pending, required 0", tag, d, exp_q[d].size());
      end
    end
  endtask

  // Hold Start high until main reports Done; steps counts edges from E0
  task automatic run_to_done(input string tag, input int budget, output int steps);
    steps = 0;
    start = 1'b1;
    while (m_done !== 1'b1 && steps < budget) begin
      step_cycle();
      steps++;
    end
    n_vec++;
    if (m_done !== 1'b1) begin
      n_miss++;
      $display("FAIL %s_timeout: got Done=%b after %0d cycles, required 1", tag, m_done, steps);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    step_cycle();
    step_cycle();
    n_vec++;
    if ({m_done, m_busy, m_aen, m_ben, m_we} !== 5'b0) begin
      n_miss++;
      $display("FAIL reset_ctrl: got %b, required 00000", {m_done, m_busy, m_aen, m_ben, m_we});
    end
    n_vec++;
    if ({m_aaddr, m_baddr, m_waddr, m_wdata} !== 16'd0) begin
      n_miss++;
      $display("FAIL reset_addr_data: got %h, required 0000", {m_aaddr, m_baddr, m_waddr, m_wdata});
    end
    n_vec++;
    if ({s_done, s_busy, n_done, n_busy, u_done, u_busy, d_done, d_busy} !== 8'd0) begin
      n_miss++;
      $display("FAIL reset_others: got %b, required 0", {s_done, s_busy, n_done, n_busy, u_done, u_busy, d_done, d_busy});
    end
    reset = 1'b0;
    step_cycle();
  endtask

  // All-ones run with a cycle-exact check of main's control and addresses
  task automatic test_timing();
    logic       exp_we, exp_busy, exp_done, exp_en;
    logic [2:0] ea, eb;
    fill_mem(0);
    push_all();
    start = 1'b1;
    for (int t = 0; t <= 19; t++) begin
      step_cycle();
      exp_we   = (t == 5) || (t == 9) || (t == 13) || (t == 17);
      exp_busy = (t <= 17);
      exp_done = (t == 18);
      exp_en   = (t <= 15);
      n_vec++;
      if ({m_we, m_busy, m_done, m_aen, m_ben} !== {exp_we, exp_busy, exp_done, exp_en, exp_en}) begin
        n_miss++;
        $display("FAIL timing_ctrl E%0d: got we/busy/done/aen/ben=%b, required %b", t,
                 {m_we, m_busy, m_done, m_aen, m_ben}, {exp_we, exp_busy, exp_done, exp_en, exp_en});
      end
      if (t <= 15) begin
        ea = 3'((t / 8) * 4 + (t % 4));
        eb = 3'((t % 4) * 2 + ((t / 4) % 2));
        n_vec++;
        if ({m_aaddr, m_baddr} !== {ea, eb}) begin
          n_miss++;
          $display("FAIL timing_addr E%0d: got A=%0d B=%0d, required A=%0d B=%0d", t, m_aaddr, m_baddr, ea, eb);
        end
      end
      // Dropping Start mid-run must not disturb the run
      if (t == 2) start = 1'b0;
    end
    check_drained("timing");
  endtask

  // Known matrices; Start held high after Done keeps Done up
  task automatic test_pattern();
    int steps;
    fill_mem(3);
    push_all();
    run_to_done("pattern", 40, steps);
    n_vec++;
    if (steps !== 19) begin
      n_miss++;
      $display("FAIL pattern_latency: got Done after E%0d, required E18", steps - 1);
    end
    for (int h = 0; h < 3; h++) begin
      step_cycle();
      n_vec++;
      if (m_done !== 1'b1) begin
        n_miss++;
        $display("FAIL pattern_done_hold: got Done=%b, required 1", m_done);
      end
    end
    check_drained("pattern");
    start = 1'b0;
    step_cycle();
    n_vec++;
    if (m_done !== 1'b0) begin
      n_miss++;
      $display("FAIL pattern_done_fall: got Done=%b, required 0", m_done);
    end
  endtask

  // All 255: clamp, shift-by-10 and truncate instances see the same data
  task automatic test_saturation();
    int steps;
    fill_mem(1);
    push_all();
    run_to_done("saturation", 40, steps);
    check_drained("saturation");
    start = 1'b0;
    step_cycle();
  endtask

  // Reset at E7 abandons the run; Start still high restarts at E8
  task automatic test_reset_midrun();
    int steps;
    fill_mem(0);
    push_all();
    start = 1'b1;
    for (int t = 0; t <= 6; t++) step_cycle();
    reset = 1'b1;
    step_cycle();
    n_vec++;
    if ({m_done, m_busy, m_aen, m_ben, m_we, m_aaddr, m_baddr, m_waddr, m_wdata} !== 21'd0) begin
      n_miss++;
      $display("FAIL midreset_outputs: got %h, required 0",
               {m_done, m_busy, m_aen, m_ben, m_we, m_aaddr, m_baddr, m_waddr, m_wdata});
    end
    for (int d = 0; d < 5; d++) exp_q[d].delete();
    reset = 1'b0;
    fill_mem(2);
    push_all();
    step_cycle();
    n_vec++;
    if (m_busy !== 1'b1) begin
      n_miss++;
      $display("FAIL midreset_restart: got Busy=%b after E8, required 1", m_busy);
    end
    run_to_done("midreset", 40, steps);
    n_vec++;
    if (steps + 1 !== 19) begin
      n_miss++;
      $display("FAIL midreset_latency: got Done %0d edges after E8, required 18", steps);
    end
    check_drained("midreset");
    start = 1'b0;
    step_cycle();
  endtask

  // Second run on fresh random data straight after a completed one
  task automatic test_back_to_back();
    int steps;
    fill_mem(2);
    push_all();
    run_to_done("b2b", 40, steps);
    check_drained("b2b");
    start = 1'b0;
    step_cycle();
    n_vec++;
    if ({m_done, m_busy} !== 2'b00) begin
      n_miss++;
      $display("FAIL b2b_idle: got Done/Busy=%b, required 00", {m_done, m_busy});
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_timing();
    test_pattern();
    test_saturation();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
